uart_32_bit_top_design: RTL and testbench
=========================================

// Module: uart_32_bit_top_design
// PURPOSE
//   Memory-mapped UART peripheral that sends and receives 32-bit words as single serial frames.
//   Each frame is 1 start bit, 32 data bits sent LSB first, and 1 stop bit.
//   A 2-bit register bus sets the baud divisor, controls the transmitter, loads TX data and reads RX data.
//   Sits between a simple CPU/bus master and the board tx/rx pins.
// PARAMETERS
//   DATA_W   32  payload bits per frame (fixed; other values are not supported)
//   OVERSMP  16  baud ticks per bit
// PORTS
//   clk           in   1   system clock; all logic on rising edge
//   rst           in   1   synchronous, active-high reset
//   address       in   2   register select: 0=BAUD, 1=CTRL/STATUS, 2=TXDATA, 3=RXDATA
//   write_enable  in   1   write strobe; register is written on every clk edge while high
//   write_data    in   32  write payload
//   read_enable   in   1   read strobe
//   read_data     out  32  registered read result
//   tx            out  1   serial output; idles high
//   rx            in   1   serial input; asynchronous, idles high
// BEHAVIOUR
//   Reset (clk edge with rst=1):
//     - BAUD=0, CTRL=0, TXDATA=0, RXDATA=0, rx_valid=0, frame_err=0, read_data=0, tx=1.
//     - Both FSMs go to IDLE.
//     - Reset mid-frame aborts the frame immediately.
//   Writes (write_enable=1):
//     - addr0 sets BAUD.
//     - addr1 sets CTRL[0]=tx_en; other bits are ignored.
//     - addr2 sets TXDATA.
//     - addr3 is read-only; writes are ignored.
//   Reads (read_enable=1): read_data is loaded on the next edge, so latency is 1 cycle.
//     - addr0 returns BAUD.
//     - addr1 returns {28'b0, frame_err, rx_valid, tx_busy, tx_en}.
//     - addr2 returns TXDATA.
//     - addr3 returns RXDATA and clears rx_valid and frame_err.
//     - With read_enable=0, read_data holds its value.
//   Baud tick:
//     - Free-running counter 0..BAUD; one-cycle tick when the counter equals BAUD, then it wraps to 0.
//     - Tick period = BAUD+1 clocks. Bit time = 16*(BAUD+1) clocks.
//     - BAUD=130 gives 2096 clk per bit.
//     - A BAUD write restarts the counter at 0.
//   TX FSM: IDLE -> START -> DATA(32) -> STOP -> IDLE.
//     - IDLE: tx=1. If tx_en=1, latch TXDATA into the shift register and go to START.
//     - START: tx=0 for 16 ticks.
//     - DATA: drives bit0..bit31, 16 ticks each, LSB first.
//     - STOP: tx=1 for 16 ticks.
//     - tx_busy=1 in every state except IDLE.
//     - tx_en is level-sensitive. While it stays 1, frames go back to back with the current TXDATA.
//     - Clearing tx_en mid-frame lets the current frame finish.
//     - Writing TXDATA mid-frame does not affect the frame in flight.
//   RX FSM: IDLE -> START -> DATA(32) -> STOP -> IDLE.
//     - rx passes through a 2-flop synchronizer first.
//     - IDLE: wait for rx=0.
//     - START: after 8 ticks (mid-bit) re-sample. If 1, treat as a glitch and go to IDLE; if 0, continue.
//     - DATA: sample every 16 ticks, 32 times, shifting LSB first.
//     - STOP: sample once after 16 more ticks.
//       - If 1: RXDATA = shift register and rx_valid=1.
//       - If 0: frame_err=1 and RXDATA is unchanged.
//     - The receiver is always enabled, independent of CTRL.
//     - A new frame before RXDATA is read overwrites it; rx_valid stays 1.
//     - If a read of addr3 and frame completion happen on the same edge, the completion wins and rx_valid=1.
//   X on rx while idle-high/unknown must not start a frame. Only a synchronized 0 starts one.
// TESTING
//   1. Reset: rst=1 for 2 cycles -> tx=1, read_data=0; reading addr1 returns 0.
//   2. Register R/W: write BAUD=130, then read addr0 with read_enable -> read_data=130 one cycle later.
//      Write addr3 -> no effect.
//   3. TX frame: BAUD=130, TXDATA=0x0F4B5A69, CTRL=1, then CTRL=0.
//      -> tx low for 2096 clk, then 32 bits LSB first (1,0,0,1,0,1,1,0,...), then high.
//      -> tx_busy=1 throughout the frame, no second frame.
//   4. RX frame: BAUD=130, 50 ns clk, drive rx at 104.8 us/bit: start 0, bits of 0x0F4B5A69 LSB first, stop 1.
//      -> rx_valid=1.
//      -> reading addr3 returns 0x0F4B5A69 and clears rx_valid.
//   5. Framing/glitch: stop bit=0 -> frame_err=1 and RXDATA unchanged.
//      A rx low pulse shorter than half a bit -> no frame and no flag.
//   6. Reset mid-TX frame -> tx=1 next cycle, tx_busy=0.

Source files
------------

// File: rtl/uart_32_bit_top_design.sv
// Memory-mapped UART that moves one 32-bit word per serial frame (start, 32 data bits LSB first, stop).
// Shared free-running baud tick drives both the transmitter and the always-on receiver.
module uart_32_bit_top_design #(
    parameter int DATA_W  = 32,
    parameter int OVERSMP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  address,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        tx,
    input  logic        rx
);

    localparam int TICK_W = $clog2(OVERSMP);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSMP - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSMP / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        REG_BAUD   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_TXDATA = 2'd2,
        REG_RXDATA = 2'd3
    } reg_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // Register file and bus side
    logic [31:0]       baud_q;
    logic [31:0]       baud_cnt_q;
    logic              tx_en_q;
    logic [DATA_W-1:0] txdata_q;
    logic [DATA_W-1:0] rxdata_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic [31:0]       read_data_q;
    logic [31:0]       rd_mux;
    logic              baud_wr;
    logic              baud_tick;
    logic              tx_busy;

    // Transmitter
    state_e            tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [TICK_W-1:0] tx_tick_q, tx_tick_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic              tx_q, tx_d;

    // Receiver
    logic              rx_meta_q, rx_sync_q;
    state_e            rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [TICK_W-1:0] rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic              rx_done_ok, rx_done_err;

    assign baud_wr   = write_enable && (address == REG_BAUD);
    assign baud_tick = (baud_cnt_q == baud_q);
    assign tx_busy   = (tx_state_q != ST_IDLE);
    assign read_data = read_data_q;
    assign tx        = tx_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || baud_wr || baud_tick) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + 32'd1;
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves rd_mux unassigned (no latch).
        rd_mux = '0;
        case (reg_e'(address))
            REG_BAUD:   rd_mux = baud_q;
            REG_CTRL:   rd_mux = {28'b0, frame_err_q, rx_valid_q, tx_busy, tx_en_q};
            REG_TXDATA: rd_mux = txdata_q;
            default:    rd_mux = rxdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q      <= '0;
            tx_en_q     <= 1'b0;
            txdata_q    <= '0;
            rxdata_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            read_data_q <= '0;
        end else begin
            if (write_enable) begin
                case (reg_e'(address))
                    REG_BAUD:   baud_q   <= write_data;
                    REG_CTRL:   tx_en_q  <= write_data[0];
                    REG_TXDATA: txdata_q <= write_data;
                    default:    ;
                endcase
            end
            if (read_enable) begin
                read_data_q <= rd_mux;
                if (address == REG_RXDATA) begin
                    rx_valid_q  <= 1'b0;
                    frame_err_q <= 1'b0;
                end
            end
            // Frame completion is written after the read-clear so it wins on a shared edge.
            if (rx_done_ok) begin
                rxdata_q   <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end
            if (rx_done_err) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_en_q) begin
                    tx_shift_d = txdata_q;
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_tick_d = tx_tick_q + TICK_W'(1);
                    if (tx_tick_q == TICK_LAST) begin
                        tx_tick_d  = '0;
                        tx_state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    tx_tick_d = tx_tick_q + TICK_W'(1);
                    if (tx_tick_q == TICK_LAST) begin
                        tx_tick_d  = '0;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        if (tx_bit_q == BIT_LAST) begin
                            tx_state_d = ST_STOP;
                        end
                    end
                end
            end
            default: begin
                if (baud_tick) begin
                    tx_tick_d = tx_tick_q + TICK_W'(1);
                    if (tx_tick_q == TICK_LAST) begin
                        tx_tick_d  = '0;
                        tx_state_d = ST_IDLE;
                    end
                end
            end
        endcase
        // The line level is registered from the next state so tx never glitches.
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_done_ok  = 1'b0;
        rx_done_err = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                // Equality against 0 keeps an unknown line from starting a frame.
                if (rx_sync_q == 1'b0) begin
                    rx_tick_d  = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    rx_tick_d = rx_tick_q + TICK_W'(1);
                    if (rx_tick_q == TICK_HALF) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = (rx_sync_q == 1'b0) ? ST_DATA : ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    rx_tick_d = rx_tick_q + TICK_W'(1);
                    if (rx_tick_q == TICK_LAST) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                        rx_bit_d   = rx_bit_q + BIT_W'(1);
                        if (rx_bit_q == BIT_LAST) begin
                            rx_state_d = ST_STOP;
                        end
                    end
                end
            end
            default: begin
                if (baud_tick) begin
                    rx_tick_d = rx_tick_q + TICK_W'(1);
                    if (rx_tick_q == TICK_LAST) begin
                        rx_tick_d   = '0;
                        rx_state_d  = ST_IDLE;
                        rx_done_ok  = (rx_sync_q == 1'b1);
                        rx_done_err = !(rx_sync_q == 1'b1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
        end
    end

endmodule

// File: tb/tb_uart_32_bit_top_design.sv
// Scoreboarded bench for uart_32_bit_top_design: bus reads and decoded tx frames are checked
// by monitors against expectations queued by the stimulus thread.
module tb_uart_32_bit_top_design;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } rd_item_t;

    logic        clk;
    logic        rst;
    logic [1:0]  address;
    logic        write_enable;
    logic [31:0] write_data;
    logic        read_enable;
    logic [31:0] read_data;
    logic        tx;
    logic        rx;

    int errors = 0;
    int checks = 0;
    int cur_baud = 0;

    rd_item_t    rd_exp[$];
    logic [31:0] tx_exp[$];

    uart_32_bit_top_design dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .tx           (tx),
        .rx           (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        wait_clks(1);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
        rd_item_t it;
        it.addr = a;
        it.data = exp;
        rd_exp.push_back(it);
        address     = a;
        read_enable = 1'b1;
        wait_clks(1);
        read_enable = 1'b0;
    endtask

    // Serial driver: one bit is 16*(BAUD+1) clocks. A bad stop bit is held low only past
    // its midpoint so the receiver sees a short low afterwards and rejects it as a glitch.
    task automatic send_rx(input logic [31:0] w, input logic stop_bit);
        int bt;
        bt = 16 * (cur_baud + 1);
        rx = 1'b0;
        wait_clks(bt);
        for (int i = 0; i < 32; i++) begin
            rx = w[i];
            wait_clks(bt);
        end
        if (stop_bit) begin
            rx = 1'b1;
            wait_clks(bt);
        end else begin
            rx = 1'b0;
            wait_clks(12 * (cur_baud + 1));
            rx = 1'b1;
            wait_clks(bt);
        end
        wait_clks(4);
    endtask

    // Read monitor: read_data is valid on the negedge after the edge that saw read_enable.
    initial begin
        rd_item_t it;
        forever begin
            @(posedge clk);
            if (read_enable && !rst) begin
                @(negedge clk);
                if (rd_exp.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL read_unexpected: got 0x%08h with no expectation queued", read_data);
                end else begin
                    it = rd_exp.pop_front();
                    check($sformatf("read_addr%0d", it.addr), read_data, it.data);
                end
            end
        end
    end

    // TX monitor: decodes frames by sampling bit centres measured from the falling start edge.
    task automatic decode_frame();
        int h, bt, start_off, stop_off, bit0_off;
        logic [31:0] w;
        logic s0, s1;
        bit aborted;
        h         = cur_baud + 1;
        bt        = 16 * h;
        start_off = bt / 2;
        bit0_off  = bt + bt / 2 - h / 2;
        stop_off  = bit0_off + 32 * bt;
        aborted   = 1'b0;
        w         = '0;
        s0        = 1'b1;
        s1        = 1'b0;
        for (int n = 1; n <= stop_off && !aborted; n++) begin
            @(negedge clk);
            if (rst) begin
                aborted = 1'b1;
            end else begin
                if (n == start_off) s0 = tx;
                for (int i = 0; i < 32; i++) begin
                    if (n == bit0_off + i * bt) w[i] = tx;
                end
                if (n == stop_off) s1 = tx;
            end
        end
        if (!aborted) begin
            if (tx_exp.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL tx_unexpected: got frame 0x%08h with no expectation queued", w);
            end else begin
                check("tx_data", w, tx_exp.pop_front());
                check("tx_start_stop", {30'b0, s0, s1}, 32'h1);
            end
        end
    endtask

    initial begin
        logic tx_prev;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && tx_prev && !tx) decode_frame();
            tx_prev = tx;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, w2, nd;
        int bt;
        rst          = 1'b1;
        rx           = 1'b1;
        address      = '0;
        write_enable = 1'b0;
        write_data   = '0;
        read_enable  = 1'b0;

        // Reset state
        wait_clks(2);
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_read_data", read_data, 32'h0);
        rst = 1'b0;
        bus_read(2'd1, 32'h0);
        bus_read(2'd3, 32'h0);

        // Register access, read-only RXDATA, CTRL ignores upper bits, read hold
        bus_write(2'd0, 32'd130);
        bus_read(2'd0, 32'd130);
        bus_write(2'd3, 32'hDEADBEEF);
        bus_read(2'd3, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFE);
        bus_read(2'd1, 32'h0);
        w = $urandom;
        bus_write(2'd2, w);
        bus_read(2'd2, w);
        wait_clks(3);
        check("read_hold", read_data, w);

        cur_baud = $urandom_range(1, 3);
        bt = 16 * (cur_baud + 1);
        bus_write(2'd0, 32'(cur_baud));

        // Single TX frame; TXDATA rewritten mid-frame must not disturb it
        bus_write(2'd2, 32'h0F4B5A69);
        tx_exp.push_back(32'h0F4B5A69);
        bus_write(2'd1, 32'h1);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, 32'h2);
        nd = $urandom;
        bus_write(2'd2, nd);
        wait_clks(36 * bt);
        bus_read(2'd1, 32'h0);
        bus_read(2'd2, nd);

        // Back-to-back frames while tx_en stays set
        w = $urandom;
        bus_write(2'd2, w);
        tx_exp.push_back(w);
        tx_exp.push_back(w);
        bus_write(2'd1, 32'h1);
        wait_clks(37 * bt);
        bus_read(2'd1, 32'h3);
        bus_write(2'd1, 32'h0);
        wait_clks(36 * bt);
        bus_read(2'd1, 32'h0);

        // RX: good frame, overwrite before read, then read clears rx_valid
        send_rx(32'h0F4B5A69, 1'b1);
        bus_read(2'd1, 32'h4);
        w = $urandom;
        send_rx(w, 1'b1);
        bus_read(2'd1, 32'h4);
        bus_read(2'd3, w);
        bus_read(2'd1, 32'h0);

        // Framing error keeps the previous RXDATA
        w2 = $urandom;
        send_rx(w2, 1'b0);
        bus_read(2'd1, 32'h8);
        bus_read(2'd3, w);
        bus_read(2'd1, 32'h0);

        // Short low pulse is a glitch: no frame, no flag
        rx = 1'b0;
        wait_clks(4 * (cur_baud + 1));
        rx = 1'b1;
        wait_clks(2 * bt);
        bus_read(2'd1, 32'h0);

        for (int k = 0; k < 2; k++) begin
            w = $urandom;
            send_rx(w, 1'b1);
            bus_read(2'd3, w);
            bus_read(2'd1, 32'h0);
        end

        // Reset in the middle of a TX frame of zeros
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h1);
        wait_clks(10 * bt);
        check("mid_tx_line_low", 32'(tx), 32'h0);
        rst = 1'b1;
        wait_clks(1);
        check("rst_mid_tx_line", 32'(tx), 32'h1);
        rst = 1'b0;
        bus_read(2'd1, 32'h0);
        bus_read(2'd0, 32'h0);
        bus_read(2'd3, 32'h0);

        wait_clks(5);
        check("tx_queue_drained", 32'(tx_exp.size()), 32'h0);
        check("rd_queue_drained", 32'(rd_exp.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
